// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store serializer:
//   - store size encodings (byte / half / word / illegal)
//   - FSM state encoding (IDLE, WRITE, DONE, ERR)
//   - helpers: index of the last byte for a size, and the alignment check
// -----------------------------------------------------------------------------
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] ST_ERR   = 2'b11;

    // nbytes-1 for a legal size; the illegal size never reaches WRITE.
    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        logic [1:0] r;
        r = 2'd0;
        case (sz)
            SZ_HALF: r = 2'd1;
            SZ_WORD: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // A request is legal when the size is defined and the address is
    // naturally aligned to it.
    function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] a_lo);
        logic r;
        r = 1'b0;
        case (sz)
            SZ_BYTE: r = 1'b1;
            SZ_HALF: r = (a_lo[0] == 1'b0);
            SZ_WORD: r = (a_lo == 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_byte_sel.sv
// -----------------------------------------------------------------------------
// store_byte_sel
// Combinational big-endian byte picker for SB/SH/SW.
// Ports:
//   size     [1:0]  store size encoding
//   idx      [1:0]  byte position within the store (0 = first written)
//   wdata    [31:0] register value; low bytes carry byte/half data
//   sel_byte [7:0]  byte to write at position idx
// -----------------------------------------------------------------------------
module store_byte_sel
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  idx,
    input  logic [31:0] wdata,
    output logic [7:0]  sel_byte
);

    always_comb begin
        sel_byte = 8'h00;
        case (size)
            SZ_BYTE: sel_byte = wdata[7:0];
            SZ_HALF: sel_byte = idx[0] ? wdata[7:0] : wdata[15:8];
            SZ_WORD: begin
                case (idx)
                    2'd0:    sel_byte = wdata[31:24];
                    2'd1:    sel_byte = wdata[23:16];
                    2'd2:    sel_byte = wdata[15:8];
                    default: sel_byte = wdata[7:0];
                endcase
            end
            default: sel_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/store_serializer.sv
// -----------------------------------------------------------------------------
// store_serializer
// Splits a 32-bit store into 1/2/4 bytes and writes them big-endian, one per
// accepted cycle, into a byte-wide data RAM. Misaligned or illegal-size
// requests are rejected with a one-cycle misaligned pulse and no write.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               store request (sampled only in IDLE)
//   size, addr, wdata   request size, byte address, register value
//   busy                high while bytes are being written
//   done                one-cycle pulse after the last byte is accepted
//   misaligned          one-cycle pulse for a rejected request
//   mem_we, mem_addr,
//   mem_wdata           byte write port (addr/data forced to 0 when idle)
//   mem_ready           memory accepts the byte on an edge with mem_we high
// -----------------------------------------------------------------------------
module store_serializer
    import store_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [1:0]        size_q,  size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        idx_q,   idx_d;
    logic [7:0]        cur_byte;

    store_byte_sel u_byte_sel (
        .size     (size_q),
        .idx      (idx_q),
        .wdata    (wdata_q),
        .sel_byte (cur_byte)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_legal(size, addr[1:0])) begin
                        addr_d  = addr;
                        size_d  = size;
                        wdata_d = wdata;
                        idx_d   = 2'd0;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WRITE: begin
                // A stalled byte keeps idx, so address and data stay put.
                if (mem_ready) begin
                    if (idx_q == last_idx(size_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            // DONE and ERR last exactly one cycle; start is ignored there.
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            wdata_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        busy       = (state_q == ST_WRITE);
        done       = (state_q == ST_DONE);
        misaligned = (state_q == ST_ERR);
        mem_we     = busy;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        if (busy) begin
            // Aligned requests never cross a wrap, so a plain add is enough.
            mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, idx_q};
            mem_wdata = cur_byte;
        end
    end

endmodule

// File: doc/store_serializer.md
Name: store_serializer

Overview:
- Store-side counterpart of the load path's sign extender: it narrows and splits a 32-bit register value into 1, 2 or 4 bytes for SB/SH/SW.
- Writes the bytes big-endian, one per accepted cycle, into the byte-wide data RAM.
- Sits between the datapath's store-data and ALU-address outputs and the data memory write port.
- Reports misaligned or illegal-size requests without touching memory.

Parameters:
- ADDR_W, 9, byte-address width of the data RAM.
- DATA_W, 32, register/store-data width; fixed at 32, kept only for readability.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  store request; sampled only in IDLE.
- size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- addr  input  ADDR_W  byte address of the store.
- wdata  input  32  register value; low bytes are used for byte/half.
- busy  output  1  high while in WRITE.
- done  output  1  one-cycle pulse after the last byte is accepted.
- misaligned  output  1  one-cycle pulse on a rejected request.
- mem_we  output  1  byte write strobe.
- mem_addr  output  ADDR_W  byte address being written.
- mem_wdata  output  8  byte being written.
- mem_ready  input  1  memory accepts the byte at this edge when mem_we is high.

Behaviour:
- Reset: state IDLE; busy, done, misaligned and mem_we are 0; mem_addr and mem_wdata are 0; internal latches are cleared.
- Reset mid-WRITE: IDLE at the next edge and mem_we drops. Bytes already accepted stay in memory; no done pulse.
- States: IDLE, WRITE, DONE, ERR.
- IDLE, start=1 with a legal aligned request: latch addr, size and wdata; idx <= 0; go to WRITE.
  - Legal aligned means: size 00 with any addr; size 01 with addr[0]=0; size 10 with addr[1:0]=00.
- IDLE, start=1 with size 11 or misaligned: go to ERR. No memory write.
- ERR: misaligned=1 for exactly one cycle, then IDLE. A start during ERR is ignored.
- WRITE:
  - mem_we=1, busy=1.
  - mem_addr = latched addr + idx, modulo 2^ADDR_W. An aligned request never wraps within itself.
  - mem_wdata = byte selected by (size, idx).
  - On an edge with mem_ready=1: if idx = nbytes-1, go to DONE; else idx <= idx+1.
  - mem_ready=0 holds idx, mem_addr and mem_wdata stable. There is no timeout.
- Byte order (big-endian):
  - size 00: idx0 = wdata[7:0].
  - size 01: idx0 = [15:8], idx1 = [7:0].
  - size 10: idx0 = [31:24], idx1 = [23:16], idx2 = [15:8], idx3 = [7:0].
- DONE: done=1, busy=0, mem_we=0 for one cycle, then IDLE. A start during DONE is ignored.
- Inputs addr, size and wdata may change after acceptance without effect.
- start held high: a new request is accepted each time the FSM returns to IDLE.
- Latency with mem_ready always 1, start sampled at edge E0:
  - mem_we is high for nbytes cycles after E0.
  - done is high in the cycle after edge E(nbytes).
  - Word store: 4 write cycles plus 1 done cycle. Byte store: 1 plus 1.
  - Error path: misaligned is high in the cycle after E0.
- Outputs mem_addr/mem_wdata are don't-care when mem_we=0; the design drives 0 in that case.

Decomposition:
- Shared package store_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_BAD=2'b11;
  - the state encoding (IDLE, WRITE, DONE, ERR);
  - a helper giving nbytes-1 per size.
- One combinational sub-module, store_byte_sel, takes (size, idx[1:0], wdata[31:0]) and returns byte[7:0]. It is reused by the bench's reference model.

Test Plan:
- SW, addr=0x010, wdata=0xDEADBEEF, mem_ready=1 -> writes 0x010=DE, 0x011=AD, 0x012=BE, 0x013=EF on four consecutive cycles; done pulses once on cycle 5; busy high for exactly 4 cycles.
- SH, addr=0x022, wdata=0x1234ABCD -> 0x022=AB, 0x023=CD; SB, addr=0x1FF, wdata=0x00000080 -> 0x1FF=80 only; done after each.
- SW, addr=0x011 and SH, addr=0x021 and size=11, addr=0x000 -> misaligned pulses one cycle each, mem_we never asserted, busy stays 0.
- SW, addr=0x040, wdata=0x01020304, mem_ready low on the 2nd and 3rd write cycles -> mem_addr=0x041/mem_wdata=02 held for 3 cycles; final memory 01 02 03 04; done 2 cycles later than the no-stall case.
- Reset asserted during the 3rd byte of SW, addr=0x080, wdata=0xAABBCCDD -> next cycle mem_we=0, busy=0, no done; memory holds 0x080=AA, 0x081=BB only.
- Back-to-back: start held high with SB, addr=0x005, wdata=0x7F -> second request accepted in the cycle after done; start asserted during DONE or ERR is not accepted.
